slave_port_ctrl: RTL and testbench

- Parametrised bus-slave port: successor of the fixed 4-way slave top (10-bit AI, 4x32 readback mux).
- Sequences one bus cycle per CARD_SEL assertion, with programmable wait states and a registered SACK_N handshake.
- Registers read data from an N-channel readback bank onto SDO, and issues single-cycle write/read strobes plus a latched register address to the DLX-side register file.
- Sits between the host card bus and the core's register/memory readback sources.

---
 rtl/slave_pkg.sv | 32 +++
 rtl/slave_rd_mux.sv | 22 ++
 rtl/slave_port_ctrl.sv | 171 +++++++++++++++++
 tb/tb_slave_port_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/slave_pkg.sv
// Shared definitions for the bus-slave port: FSM encoding, default widths
// and a constant-evaluable log2 helper.
package slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam int DEF_AW       = 10;
  localparam int DEF_DW       = 32;
  localparam int DEF_NCH      = 4;
  localparam int DEF_SEL_LSB  = 5;
  localparam int DEF_REG_AW   = 5;
  localparam int DEF_WAIT_CYC = 1;

  // Wait-state counter width; WAIT_CYC is limited to 0..15.
  localparam int WAIT_CW = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slave_rd_mux.sv
// NCH:1 readback channel mux; channel k lives at bank_i[k*DW +: DW].
module slave_rd_mux
  import slave_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int DW   = DEF_DW,
  parameter int SELW = clog2(DEF_NCH)
) (
  input  logic [NCH*DW-1:0] bank_i,
  input  logic [SELW-1:0]   sel_i,
  output logic [DW-1:0]     dout_o
);

  // Pick the selected channel; purely combinational, registered by the caller.
  always_comb begin
    dout_o = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_i == SELW'(k)) dout_o = bank_i[k*DW +: DW];
    end
  end

endmodule

// File: rtl/slave_port_ctrl.sv
// Parametrised host-bus slave port: sequences one bus cycle per CARD_SEL,
// inserts programmable wait states, returns readback data on SDO and issues
// single-cycle read/write strobes towards the register file.
//
// state | meaning
// IDLE  | waiting for CARD_SEL; latches address, direction and write data
// WAIT  | counting wait states; CARD_SEL low aborts without side effects
// ACK   | one cycle: loads SDO (read) or fires WR_STB (write), drives SACK_N low
// HOLD  | keeps SACK_N low until CARD_SEL drops, then back to IDLE
module slave_port_ctrl
  import slave_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int NCH      = DEF_NCH,
  parameter int SEL_LSB  = DEF_SEL_LSB,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CARD_SEL,
  input  logic [AW-1:0]     AI,
  input  logic              WR_IN_N,
  input  logic [DW-1:0]     SDI,
  input  logic [NCH*DW-1:0] RD_BANK,
  output logic              SACK_N,
  output logic [DW-1:0]     SDO,
  output logic [REG_AW-1:0] REG_ADDR,
  output logic              WR_STB,
  output logic [DW-1:0]     WR_DATA,
  output logic              RD_STB,
  output logic              BUSY
);

  localparam int SELW = clog2(NCH);

  // The down-counter is loaded with WAIT_CYC-1 so that terminal count (0)
  // is reached after exactly WAIT_CYC cycles in WAIT.
  localparam logic [WAIT_CW-1:0] WAIT_LOAD =
    (WAIT_CYC > 0) ? WAIT_CW'(WAIT_CYC - 1) : '0;

  state_e              state_q, state_d;
  logic [WAIT_CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [SELW-1:0]     sel_lat_q, sel_lat_d;
  logic                rd_lat_q, rd_lat_d;
  logic [DW-1:0]       wr_data_q, wr_data_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic [DW-1:0]       sdo_q, sdo_d;
  logic                sack_n_q, sack_n_d;
  logic                wr_stb_q, wr_stb_d;
  logic                rd_stb_q, rd_stb_d;
  logic                busy_q, busy_d;
  logic [DW-1:0]       rd_mux_out;

  // Address bits outside the register and channel fields carry no meaning here.
  logic                unused_ai;
  assign unused_ai = ^AI;

  slave_rd_mux #(
    .NCH  (NCH),
    .DW   (DW),
    .SELW (SELW)
  ) u_rd_mux (
    .bank_i (RD_BANK),
    .sel_i  (sel_lat_q),
    .dout_o (rd_mux_out)
  );

  // Next-state and next-output computation for the bus-cycle sequencer.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sel_lat_d  = sel_lat_q;
    rd_lat_d   = rd_lat_q;
    wr_data_d  = wr_data_q;
    reg_addr_d = reg_addr_q;
    sdo_d      = sdo_q;
    sack_n_d   = sack_n_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (CARD_SEL) begin
          sel_lat_d  = AI[SEL_LSB +: SELW];
          rd_lat_d   = WR_IN_N;
          wr_data_d  = SDI;
          reg_addr_d = AI[REG_AW-1:0];
          if (WAIT_CYC > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_WAIT: begin
        if (!CARD_SEL) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        // Strobe fires even if CARD_SEL already dropped; HOLD then releases.
        if (rd_lat_q) begin
          sdo_d    = rd_mux_out;
          rd_stb_d = 1'b1;
        end else begin
          wr_stb_d = 1'b1;
        end
        sack_n_d = 1'b0;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (!CARD_SEL) begin
          sack_n_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sack_n_d = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter, latches and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      sel_lat_q  <= '0;
      rd_lat_q   <= 1'b0;
      wr_data_q  <= '0;
      reg_addr_q <= '0;
      sdo_q      <= '0;
      sack_n_q   <= 1'b1;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      sel_lat_q  <= sel_lat_d;
      rd_lat_q   <= rd_lat_d;
      wr_data_q  <= wr_data_d;
      reg_addr_q <= reg_addr_d;
      sdo_q      <= sdo_d;
      sack_n_q   <= sack_n_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign SACK_N   = sack_n_q;
  assign SDO      = sdo_q;
  assign REG_ADDR = reg_addr_q;
  assign WR_STB   = wr_stb_q;
  assign WR_DATA  = wr_data_q;
  assign RD_STB   = rd_stb_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_slave_port_ctrl.sv
// Bench for slave_port_ctrl: three instances (WAIT_CYC=1 / 4 ch,
// WAIT_CYC=3 / 4 ch, WAIT_CYC=0 / 8 ch) share one stimulus stream. Expected
// behaviour per bus cycle comes from a transaction-level timing model.
module tb_slave_port_ctrl;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_sel;
  logic [9:0]  ai;
  logic        wr_in_n;
  logic [31:0] sdi;
  logic [31:0] bank_v [8];
  logic [255:0] rd_bank8;
  logic [127:0] rd_bank4;

  logic        sack_n_o   [ND];
  logic [31:0] sdo_o      [ND];
  logic [4:0]  reg_addr_o [ND];
  logic        wr_stb_o   [ND];
  logic [31:0] wr_data_o  [ND];
  logic        rd_stb_o   [ND];
  logic        busy_o     [ND];

  logic [31:0] sdo_exp [ND];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    rd_bank8 = '0;
    for (int k = 0; k < 8; k++) rd_bank8[k*32 +: 32] = bank_v[k];
  end
  assign rd_bank4 = rd_bank8[127:0];

  slave_port_ctrl u_dut_w1 (
    .CLK(clk), .RESET_N(rst_n), .CARD_SEL(card_sel), .AI(ai), .WR_IN_N(wr_in_n),
    .SDI(sdi), .RD_BANK(rd_bank4), .SACK_N(sack_n_o[0]), .SDO(sdo_o[0]),
    .REG_ADDR(reg_addr_o[0]), .WR_STB(wr_stb_o[0]), .WR_DATA(wr_data_o[0]),
    .RD_STB(rd_stb_o[0]), .BUSY(busy_o[0])
  );

  slave_port_ctrl #(.WAIT_CYC(3)) u_dut_w3 (
    .CLK(clk), .RESET_N(rst_n), .CARD_SEL(card_sel), .AI(ai), .WR_IN_N(wr_in_n),
    .SDI(sdi), .RD_BANK(rd_bank4), .SACK_N(sack_n_o[1]), .SDO(sdo_o[1]),
    .REG_ADDR(reg_addr_o[1]), .WR_STB(wr_stb_o[1]), .WR_DATA(wr_data_o[1]),
    .RD_STB(rd_stb_o[1]), .BUSY(busy_o[1])
  );

  slave_port_ctrl #(.NCH(8), .WAIT_CYC(0)) u_dut_n8 (
    .CLK(clk), .RESET_N(rst_n), .CARD_SEL(card_sel), .AI(ai), .WR_IN_N(wr_in_n),
    .SDI(sdi), .RD_BANK(rd_bank8), .SACK_N(sack_n_o[2]), .SDO(sdo_o[2]),
    .REG_ADDR(reg_addr_o[2]), .WR_STB(wr_stb_o[2]), .WR_DATA(wr_data_o[2]),
    .RD_STB(rd_stb_o[2]), .BUSY(busy_o[2])
  );

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int nch_of(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < ND; d++) begin
      check({tag, "_sack_n"},   d, 32'(sack_n_o[d]),   32'd1);
      check({tag, "_sdo"},      d, sdo_o[d],           32'd0);
      check({tag, "_reg_addr"}, d, 32'(reg_addr_o[d]), 32'd0);
      check({tag, "_wr_stb"},   d, 32'(wr_stb_o[d]),   32'd0);
      check({tag, "_rd_stb"},   d, 32'(rd_stb_o[d]),   32'd0);
      check({tag, "_wr_data"},  d, wr_data_o[d],       32'd0);
      check({tag, "_busy"},     d, 32'(busy_o[d]),     32'd0);
    end
  endtask

  task automatic randomize_bank();
    for (int k = 0; k < 8; k++) bank_v[k] = $urandom;
  endtask

  // One bus cycle: CARD_SEL sampled high on h consecutive edges, then low for
  // gap edges. A cycle with W wait states completes iff h >= W+1; its outputs
  // change on edge offset a = W+1, SACK_N is released on the first low edge
  // at or after offset a+1. An aborted cycle goes idle on the first low edge.
  task automatic run_cycle(input logic [9:0] addr, input logic wrn, input logic [31:0] data,
                           input int h, input int gap);
    bit          complete [ND];
    int          a        [ND];
    int          rel      [ND];
    logic [31:0] rdval    [ND];
    bit          fire;
    for (int d = 0; d < ND; d++) begin
      complete[d] = (h >= wait_of(d) + 1);
      a[d]        = wait_of(d) + 1;
      rel[d]      = complete[d] ? ((a[d] + 1 > h) ? a[d] + 1 : h) : h;
      rdval[d]    = bank_v[(int'(addr) / 32) % nch_of(d)];
    end
    card_sel = 1'b1;
    ai       = addr;
    wr_in_n  = wrn;
    sdi      = data;
    for (int j = 0; j < h + gap; j++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        fire = complete[d] && (j == a[d]);
        if (fire && wrn) sdo_exp[d] = rdval[d];
        check("sack_n", d, 32'(sack_n_o[d]),
              (complete[d] && j >= a[d] && j < rel[d]) ? 32'd0 : 32'd1);
        check("busy",     d, 32'(busy_o[d]),     32'(j < rel[d]));
        check("rd_stb",   d, 32'(rd_stb_o[d]),   32'(fire && wrn));
        check("wr_stb",   d, 32'(wr_stb_o[d]),   32'(fire && !wrn));
        check("sdo",      d, sdo_o[d],           sdo_exp[d]);
        check("reg_addr", d, 32'(reg_addr_o[d]), 32'(addr[4:0]));
        if (fire && !wrn) check("wr_data", d, wr_data_o[d], data);
      end
      @(negedge clk);
      if (j == 0) begin
        ai      = 10'($urandom);
        wr_in_n = 1'($urandom);
        sdi     = $urandom;
      end
      if (j == h - 1) card_sel = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    card_sel = 1'b0;
    ai       = '0;
    wr_in_n  = 1'b1;
    sdi      = '0;
    for (int d = 0; d < ND; d++) sdo_exp[d] = '0;
    randomize_bank();

    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed read: channel 2, REG_ADDR 5.
    bank_v[2] = 32'hDEADBEEF;
    run_cycle(10'h045, 1'b1, 32'h0, 3, 6);

    // Directed write: REG_ADDR 31, SDO untouched.
    run_cycle(10'h01F, 1'b0, 32'h12345678, 4, 6);

    // Drop after one wait cycle: aborts the WAIT_CYC=3 instance only.
    randomize_bank();
    run_cycle(10'h0A3, 1'b1, 32'h0, 2, 6);

    // Channel sweep via AI[7:5].
    for (int k = 0; k < 8; k++) begin
      randomize_bank();
      run_cycle(10'(k * 32 + k + 3), 1'b1, 32'h0, (k % 2 == 1) ? 1 : 5, 6);
    end

    // Randomized cycles: direction, data, select length and gap.
    for (int n = 0; n < 30; n++) begin
      randomize_bank();
      run_cycle(10'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(1, 8)), int'($urandom_range(6, 8)));
    end

    // CARD_SEL held high well beyond the acknowledge: one strobe only.
    randomize_bank();
    run_cycle(10'h1C4, 1'b1, 32'h0, 12, 6);
    run_cycle(10'h2E9, 1'b0, 32'hCAFEF00D, 12, 6);

    // Async reset while every instance sits in HOLD.
    randomize_bank();
    card_sel = 1'b1;
    ai       = 10'h06A;
    wr_in_n  = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    for (int d = 0; d < ND; d++) sdo_exp[d] = '0;
    card_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    randomize_bank();
    run_cycle(10'h0E6, 1'b1, 32'h0, 5, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
